cover_toggle_drain_ctrl: RTL and testbench

//  Drain controller for one group of toggle-coverage points. Captures a WIDTH-bit
//  per-cycle hit vector into a sticky pending set, then reports the hits one at a

---
 rtl/cover_toggle_drain_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_cover_toggle_drain_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cover_toggle_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cover_toggle_drain_ctrl
//  Purpose  : Drain controller for one group of toggle-coverage points.
//             A WIDTH-bit per-cycle hit vector is merged into a sticky
//             pending set; hits are then reported one per accepted transfer,
//             as global cover indices, over a valid/ready port to the
//             shared reporting sink. Selection is round-robin starting just
//             past the last accepted bit.
//  Ports    : clock     - single clock, posedge
//             reset     - synchronous, active-high
//             valid     - per-cycle hits, bit i = point COVER_INDEX+i
//             cover_en  - capture enable (valid ignored when low)
//             clear     - drop all pending/covered state, zero the counter
//             out_valid - report available
//             out_ready - sink accepts report
//             out_index - COVER_INDEX + reported bit position
//             hit_count - accepted reports since reset/clear (saturating)
//             busy      - pending set nonzero or report outstanding
//  Options  : COVER_TOGGLE_DEDUP_EN - when defined, each point is reported
//             at most once until clear/reset.
//  Revision : 1.0 - initial release
// ============================================================================
module cover_toggle_drain_ctrl #(
    parameter int WIDTH       = 40,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 38253,
    parameter int IDX_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] valid,
    input  logic             cover_en,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W-1:0] hit_count,
    output logic             busy
);

    localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] c_HIT_MAX = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] c_BASE    = IDX_W'(COVER_INDEX);

    // Elaboration-time range checks
    generate
        if ((COVER_INDEX + WIDTH) > COVER_TOTAL) begin : g_range_err
            $error("cover_toggle_drain_ctrl: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
        end
        if ((WIDTH < 1) || (WIDTH > 256)) begin : g_width_err
            $error("cover_toggle_drain_ctrl: WIDTH must be 1..256");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_pending;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_sel;
    logic               r_out_valid;
    logic [IDX_W-1:0]   r_out_index;
    logic [IDX_W-1:0]   r_hit_count;

    state_t             w_state_next;
    logic               w_out_valid_next;
    logic [IDX_W-1:0]   w_out_index_next;
    logic [IDX_W-1:0]   w_hit_count_next;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [PTR_W-1:0]   w_sel_next;

    logic               w_accept;
    logic [PTR_W-1:0]   w_sel_succ;
    logic [PTR_W-1:0]   w_start;
    logic               w_found;
    logic [PTR_W-1:0]   w_sel;
    logic [WIDTH-1:0]   w_sel_onehot;
    logic               w_take;
    logic [WIDTH-1:0]   w_take_mask;
    logic [WIDTH-1:0]   w_block;
    logic [WIDTH-1:0]   w_capture;
    logic [WIDTH-1:0]   w_pending_next;

    assign w_accept = r_out_valid & out_ready;

    // Position following the currently held bit, wrapping WIDTH-1 -> 0.
    assign w_sel_succ = (int'(r_sel) == (WIDTH - 1)) ? '0 : (r_sel + 1'b1);

    // After an accept the search resumes just past the accepted bit, which is
    // exactly where the pointer is about to move; in IDLE the pointer is current.
    assign w_start = (r_state == ST_ISSUE) ? w_sel_succ : r_ptr;

    // Round-robin first-set search starting at w_start.
    always_comb begin
        int j;
        j            = 0;
        w_found      = 1'b0;
        w_sel        = '0;
        w_sel_onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            j = int'(w_start) + i;
            if (j >= WIDTH) begin
                j = j - WIDTH;
            end
            if (!w_found && r_pending[j]) begin
                w_found         = 1'b1;
                w_sel           = PTR_W'(j);
                w_sel_onehot[j] = 1'b1;
            end
        end
    end

    // A new selection happens from IDLE, or back-to-back on an accept.
    assign w_take      = w_found & ((r_state == ST_IDLE) | w_accept);
    assign w_take_mask = w_take ? w_sel_onehot : '0;

`ifdef COVER_TOGGLE_DEDUP_EN
    logic [WIDTH-1:0] r_covered;

    // Include the bit being selected right now so a same-cycle hit on it
    // cannot slip back into pending before covered updates.
    assign w_block = r_covered | w_take_mask;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_covered <= '0;
        end else begin
            r_covered <= r_covered | w_take_mask;
        end
    end
`else
    assign w_block = '0;
`endif

    assign w_capture      = cover_en ? (valid & ~w_block) : '0;
    // Selected bit leaves pending first, so a fresh hit on it re-enters.
    assign w_pending_next = (r_pending & ~w_take_mask) | w_capture;

    // Next-state / output logic
    always_comb begin
        w_state_next     = r_state;
        w_out_valid_next = r_out_valid;
        w_out_index_next = r_out_index;
        w_hit_count_next = r_hit_count;
        w_ptr_next       = r_ptr;
        w_sel_next       = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_sel_next       = w_sel;
                    w_out_index_next = c_BASE + IDX_W'(w_sel);
                    w_out_valid_next = 1'b1;
                    w_state_next     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_accept) begin
                    if (r_hit_count != c_HIT_MAX) begin
                        w_hit_count_next = r_hit_count + 1'b1;
                    end
                    w_ptr_next = w_sel_succ;
                    if (w_found) begin
                        w_sel_next       = w_sel;
                        w_out_index_next = c_BASE + IDX_W'(w_sel);
                        w_out_valid_next = 1'b1;
                    end else begin
                        w_out_valid_next = 1'b0;
                        w_state_next     = ST_IDLE;
                    end
                end
            end
            default: begin
                w_out_valid_next = 1'b0;
                w_state_next     = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_hit_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pending   <= w_pending_next;
            r_ptr       <= w_ptr_next;
            r_sel       <= w_sel_next;
            r_out_valid <= w_out_valid_next;
            r_out_index <= w_out_index_next;
            r_hit_count <= w_hit_count_next;
        end
    end

    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign hit_count = r_hit_count;
    assign busy      = (|r_pending) | r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_cover_toggle_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cover_toggle_drain_ctrl
//  Purpose  : Self-checking bench for cover_toggle_drain_ctrl: directed
//             scenarios with literal expectations, followed by randomized
//             traffic compared every cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cover_toggle_drain_ctrl;

    localparam int W    = 40;
    localparam int BASE = 100;
    localparam int IW   = 16;

    logic          clock;
    logic          reset;
    logic [W-1:0]  valid;
    logic          cover_en;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_index;
    logic [IW-1:0] hit_count;
    logic          busy;

    int tests = 0;
    int fails = 0;

    cover_toggle_drain_ctrl #(
        .WIDTH(W), .COVER_INDEX(BASE), .COVER_TOTAL(38253), .IDX_W(IW)
    ) dut (
        .clock(clock), .reset(reset), .valid(valid), .cover_en(cover_en),
        .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .hit_count(hit_count), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_pend;
    logic [W-1:0] m_cov;
    logic         m_valid;
    int           m_sel;
    int           m_ptr;
    int           m_cnt;
    bit           m_ok = 1'b0;

    always @(posedge clock) begin
        if (reset || clear) begin
            m_pend = '0; m_cov = '0; m_valid = 1'b0;
            m_sel = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (m_valid && out_ready) begin
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                m_ptr   = (m_sel + 1) % W;
                m_valid = 1'b0;
            end
            if (!m_valid) begin
                for (int k = 0; k < W; k++) begin
                    if (!m_valid && m_pend[(m_ptr + k) % W]) begin
                        m_sel         = (m_ptr + k) % W;
                        m_pend[m_sel] = 1'b0;
                        m_cov[m_sel]  = 1'b1;
                        m_valid       = 1'b1;
                    end
                end
            end
            if (cover_en) begin
                for (int i = 0; i < W; i++) begin
`ifdef COVER_TOGGLE_DEDUP_EN
                    if (valid[i] && !m_cov[i]) m_pend[i] = 1'b1;
`else
                    if (valid[i]) m_pend[i] = 1'b1;
`endif
                end
            end
        end
        m_ok = 1'b1;
    end

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (m_ok) begin
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("m_busy", {31'd0, busy}, {31'd0, (m_pend != '0) || m_valid});
            chk("m_hit_count", {16'd0, hit_count}, m_cnt);
            if (m_valid) chk("m_out_index", {16'd0, out_index}, BASE + m_sel);
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    logic [63:0] rnd;

    initial begin
        reset = 1'b1; valid = '0; cover_en = 1'b1; clear = 1'b0; out_ready = 1'b1;
        // 1: reset and idle
        repeat (3) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_hit_count", {16'd0, hit_count}, 0);
        reset = 1'b0;
        repeat (10) tick();
        chk("idle_out_valid", {31'd0, out_valid}, 0);
        chk("idle_busy", {31'd0, busy}, 0);

        // 2: three hits, back-to-back reports
        valid = '0; valid[0] = 1'b1; valid[5] = 1'b1; valid[39] = 1'b1;
        tick(); valid = '0;
        chk("t2_latency", {31'd0, out_valid}, 0);
        chk("t2_busy", {31'd0, busy}, 1);
        tick(); chk("t2_idx0", {16'd0, out_index}, 100); chk("t2_v0", {31'd0, out_valid}, 1);
        tick(); chk("t2_idx1", {16'd0, out_index}, 105);
        tick(); chk("t2_idx2", {16'd0, out_index}, 139);
        tick(); chk("t2_done", {31'd0, out_valid}, 0);
        chk("t2_count", {16'd0, hit_count}, 3);

        // 3: back-pressure holds the report
        do_clear();
        out_ready = 1'b0; valid = '0; valid[7] = 1'b1;
        tick(); valid = '0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("t3_hold_idx", {16'd0, out_index}, 107);
            chk("t3_hold_v", {31'd0, out_valid}, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("t3_after_v", {31'd0, out_valid}, 0);
        chk("t3_count", {16'd0, hit_count}, 1);

        // 4: same bit hit every cycle
        do_clear();
        valid = '0; valid[3] = 1'b1;
        repeat (6) tick();
`ifdef COVER_TOGGLE_DEDUP_EN
        chk("t4_count", {16'd0, hit_count}, 1);
        chk("t4_v", {31'd0, out_valid}, 0);
`else
        chk("t4_count", {16'd0, hit_count}, 4);
        chk("t4_idx", {16'd0, out_index}, 103);
`endif
        valid = '0;
        repeat (4) tick();

        // 5: wrap-around round-robin from ptr=38
        do_clear();
        valid = '0; valid[37] = 1'b1;
        tick(); valid = '0;
        tick(); tick();
        valid[1] = 1'b1; valid[39] = 1'b1;
        tick(); valid = '0;
        tick(); chk("t5_first", {16'd0, out_index}, 139);
        tick(); chk("t5_second", {16'd0, out_index}, 101);
        tick();

        // 6: clear with report outstanding and bits pending
        do_clear();
        out_ready = 1'b0;
        valid = '0; valid[2] = 1'b1; valid[4] = 1'b1; valid[6] = 1'b1;
        valid[8] = 1'b1; valid[10] = 1'b1;
        tick(); valid = '0;
        tick();
        chk("t6_pre_v", {31'd0, out_valid}, 1);
        clear = 1'b1; valid[12] = 1'b1;
        tick(); clear = 1'b0; valid = '0;
        chk("t6_v", {31'd0, out_valid}, 0);
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_count", {16'd0, hit_count}, 0);
        out_ready = 1'b1; valid[2] = 1'b1;
        tick(); valid = '0;
        tick();
        chk("t6_again", {16'd0, out_index}, 102);
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rnd = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) valid = rnd[39:0];
            else if ($urandom_range(0, 1) == 0) valid = rnd[39:0] & {$urandom, $urandom} & {$urandom, $urandom};
            else valid = '0;
            cover_en  = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 199) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; clear = 1'b0; valid = '0; out_ready = 1'b1;
        repeat (60) tick();
        chk("final_idle", {31'd0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
